// File: rtl/bsv_small_fifo.sv
// Register-based FIFO of depth 1 or 2 with FULL_N/EMPTY_N status and synchronous clear.
// Optional FIFO_ERROR_CHECK_EN adds simulation-only overflow/underflow warnings.
module bsv_small_fifo #(
  parameter int width = 8,
  parameter int depth = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [width-1:0] D_IN,
  input  logic             ENQ,
  input  logic             DEQ,
  input  logic             CLR,
  output logic [width-1:0] D_OUT,
  output logic             FULL_N,
  output logic             EMPTY_N
);

  generate
    if (depth != 1 && depth != 2) begin : g_bad_depth
      $error("bsv_small_fifo: depth must be 1 or 2");
    end
    if (width < 1) begin : g_bad_width
      $error("bsv_small_fifo: width must be at least 1");
    end
  endgenerate

  localparam logic [1:0] DEPTH_C = depth[1:0];

  logic [1:0]       count_q, count_d;
  logic [width-1:0] data0_q, data0_d;
  logic [width-1:0] data1_q, data1_d;
  logic             enq_eff, deq_eff;

  assign FULL_N  = (count_q < DEPTH_C);
  assign EMPTY_N = (count_q != 2'd0);
  assign D_OUT   = data0_q;

  assign enq_eff = ENQ & FULL_N;
  assign deq_eff = DEQ & EMPTY_N;

  always_comb begin
    count_d = count_q;
    data0_d = data0_q;
    data1_d = data1_q;
    if (CLR) begin
      count_d = 2'd0;
    end else begin
      case ({enq_eff, deq_eff})
        2'b10: begin
          if (count_q == 2'd0) begin
            data0_d = D_IN;
            count_d = 2'd1;
          end else begin
            data1_d = D_IN;
            count_d = 2'd2;
          end
        end
        2'b01: begin
          if (count_q == 2'd2) begin
            data0_d = data1_q;
          end
          count_d = count_q - 2'd1;
        end
        // Only reachable at count 1 of a two-entry FIFO: replace the head in place.
        2'b11: begin
          data0_d = D_IN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      count_q <= 2'd0;
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      count_q <= count_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
    end
  end

`ifdef FIFO_ERROR_CHECK_EN
  always @(posedge CLK) begin
    if (RST_N && !CLR) begin
      if (ENQ && !FULL_N)  $display("%m: enqueue to full FIFO");
      if (DEQ && !EMPTY_N) $display("%m: dequeue from empty FIFO");
    end
  end
`endif

endmodule

// File: tb/tb_bsv_small_fifo.sv
// Directed bench for bsv_small_fifo: one depth-2 and one depth-1 instance.
module tb_bsv_small_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din2, din1;
  logic       enq2, deq2, clr2, enq1, deq1, clr1;
  logic [7:0] dout2, dout1;
  logic       full2, empty2, full1, empty1;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  bsv_small_fifo #(.width(8), .depth(2)) u_fifo2 (
    .CLK(clk), .RST_N(rst_n), .D_IN(din2), .ENQ(enq2), .DEQ(deq2), .CLR(clr2),
    .D_OUT(dout2), .FULL_N(full2), .EMPTY_N(empty2)
  );

  bsv_small_fifo #(.width(8), .depth(1)) u_fifo1 (
    .CLK(clk), .RST_N(rst_n), .D_IN(din1), .ENQ(enq1), .DEQ(deq1), .CLR(clr1),
    .D_OUT(dout1), .FULL_N(full1), .EMPTY_N(empty1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv2(input logic e, input logic d, input logic c, input logic [7:0] v);
    enq2 = e; deq2 = d; clr2 = c; din2 = v;
  endtask

  initial begin
    rst_n = 1'b0;
    drv2(0, 0, 0, 8'h00);
    enq1 = 0; deq1 = 0; clr1 = 0; din1 = 8'h00;
    tick(); tick();
    chk("rst_empty", 32'(empty2), 0);
    chk("rst_full", 32'(full2), 1);
    chk("rst_dout", 32'(dout2), 32'h00);
    chk("rst_d1_empty", 32'(empty1), 0);
    rst_n = 1'b1;

    // fill
    drv2(1, 0, 0, 8'h11); tick();
    chk("fill1_empty", 32'(empty2), 1);
    chk("fill1_dout", 32'(dout2), 32'h11);
    chk("fill1_full", 32'(full2), 1);
    drv2(1, 0, 0, 8'h22); tick();
    chk("fill2_full", 32'(full2), 0);
    chk("fill2_dout", 32'(dout2), 32'h11);
    drv2(1, 0, 0, 8'h33); tick();
    chk("ovf_full", 32'(full2), 0);
    chk("ovf_dout", 32'(dout2), 32'h11);

    // drain
    drv2(0, 1, 0, 8'h00); tick();
    chk("drain1_dout", 32'(dout2), 32'h22);
    chk("drain1_full", 32'(full2), 1);
    chk("drain1_empty", 32'(empty2), 1);
    tick();
    chk("drain2_empty", 32'(empty2), 0);
    tick();
    chk("drain3_empty", 32'(empty2), 0);
    chk("drain3_full", 32'(full2), 1);

    // simultaneous enq+deq at count 1
    drv2(1, 0, 0, 8'hA5); tick();
    chk("head_a5", 32'(dout2), 32'hA5);
    drv2(1, 1, 0, 8'h5A); tick();
    chk("ed_dout", 32'(dout2), 32'h5A);
    chk("ed_full", 32'(full2), 1);
    chk("ed_empty", 32'(empty2), 1);
    drv2(1, 0, 0, 8'h66); tick();
    chk("ed_cnt2_full", 32'(full2), 0);
    chk("ed_cnt2_dout", 32'(dout2), 32'h5A);
    drv2(0, 1, 0, 8'h00); tick();
    chk("ed_shift_dout", 32'(dout2), 32'h66);

    // enq+deq on full: deq only
    drv2(1, 0, 0, 8'h77); tick();
    chk("full_again", 32'(full2), 0);
    drv2(1, 1, 0, 8'h88); tick();
    chk("fed_dout", 32'(dout2), 32'h77);
    chk("fed_full", 32'(full2), 1);
    drv2(0, 1, 0, 8'h00); tick();
    chk("fed_drop_empty", 32'(empty2), 0);

    // clear with concurrent enq/deq
    drv2(1, 0, 0, 8'h01); tick();
    drv2(1, 0, 0, 8'h02); tick();
    chk("clr_pre_full", 32'(full2), 0);
    drv2(1, 1, 1, 8'h03); tick();
    chk("clr_empty", 32'(empty2), 0);
    chk("clr_full", 32'(full2), 1);
    chk("clr_keep_data", 32'(dout2), 32'h01);
    drv2(0, 0, 0, 8'h00); tick();
    chk("clr_hold_empty", 32'(empty2), 0);

    // depth 1
    enq1 = 1; din1 = 8'h7E; tick();
    chk("d1_full", 32'(full1), 0);
    chk("d1_empty", 32'(empty1), 1);
    chk("d1_dout", 32'(dout1), 32'h7E);
    enq1 = 1; deq1 = 1; din1 = 8'h01; tick();
    chk("d1_ed_empty", 32'(empty1), 0);
    chk("d1_ed_full", 32'(full1), 1);
    enq1 = 1; deq1 = 0; din1 = 8'h01; tick();
    chk("d1_re_dout", 32'(dout1), 32'h01);
    chk("d1_re_full", 32'(full1), 0);
    enq1 = 0; deq1 = 1; tick();
    chk("d1_deq_empty", 32'(empty1), 0);
    enq1 = 0; deq1 = 0;

    // reset during a stream
    drv2(1, 0, 0, 8'h04); tick();
    drv2(1, 0, 0, 8'h05); tick();
    chk("stream_full", 32'(full2), 0);
    drv2(1, 1, 0, 8'h06);
    rst_n = 1'b0; tick();
    chk("mid_rst_empty", 32'(empty2), 0);
    chk("mid_rst_full", 32'(full2), 1);
    chk("mid_rst_dout", 32'(dout2), 32'h00);
    rst_n = 1'b1;
    drv2(0, 0, 0, 8'h00); tick();
    chk("post_rst_empty", 32'(empty2), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bsv_small_fifo.md
# bsv_small_fifo

Register-based FIFO of depth 1 or 2 (selected by parameter), with an explicit ready/valid status interface (FULL_N / EMPTY_N) and a synchronous clear. It is the standard small buffering element between producer and consumer rules: in the register-mapped wrapper, input operand queues and result queues are built from it. One module covers both the single-entry and the two-entry variant, so there is no bypass path and no combinational path from D_IN to D_OUT.

## Interface
- width, default 8: data width in bits, ≥1.
- depth, default 2: number of entries; legal values 1 and 2 only; any other value is an elaboration error.

- CLK  in  1  rising-edge clock.
- RST_N  in  1  reset: synchronous, active-low, sampled on the rising edge of CLK.
- D_IN  in  width  enqueue data.
- ENQ  in  1  enqueue request; honoured only when FULL_N=1.
- DEQ  in  1  dequeue request; honoured only when EMPTY_N=1.
- CLR  in  1  synchronous clear: empties the FIFO.
- D_OUT  out  width  head entry; valid only while EMPTY_N=1.
- FULL_N  out  1  1 = at least one free entry.
- EMPTY_N  out  1  1 = at least one valid entry.

## Operation
- State: data0 (head), data1 (second entry, depth 2 only), occupancy count 0..depth. D_OUT = data0 always.
- FULL_N = (count < depth); EMPTY_N = (count > 0); both decoded from registered state only.
- Priority per clock edge: reset > CLR > ENQ/DEQ.
- CLR=1: count ← 0. Data registers keep their values. Concurrent ENQ/DEQ are discarded.
- Effective enq = ENQ & FULL_N. Effective deq = DEQ & EMPTY_N. The FULL_N/EMPTY_N values used are the ones at the start of the cycle.
- Enq on a full FIFO is dropped, including when DEQ is asserted in the same cycle. Deq on an empty FIFO is ignored.
- Depth 2 transitions:
  - count 0, enq → data0 ← D_IN, count 1.
  - count 1, enq only → data1 ← D_IN, count 2.
  - count 1, deq only → count 0.
  - count 1, enq+deq → data0 ← D_IN, count stays 1.
  - count 2, deq → data0 ← data1, count 1.
- Depth 1 transitions:
  - count 0, enq → data0 ← D_IN, count 1.
  - count 1, deq → count 0.
- Order is strict FIFO. There is no wrap-around beyond the 2-entry shift.

## Timing
- Reset:
  - When RST_N=0 at a rising edge, the next state is count=0 and data registers = 0.
  - Outputs after reset: EMPTY_N=0, FULL_N=1, D_OUT=0.
  - Reset asserted mid-operation discards all contents in that same edge.
- Enq-to-visible latency is 1 cycle: data enqueued at edge N appears on D_OUT, with EMPTY_N=1, after edge N.
- Deq takes effect at the edge. The next entry, or EMPTY_N=0, is visible after that edge.
- FULL_N drops the cycle after the enqueue that fills the FIFO. It rises the cycle after a dequeue from full.
- Producer handshake: the producer may hold ENQ high continuously; a transfer occurs on every edge where ENQ=1 and FULL_N=1.
- Consumer handshake: same rule with DEQ and EMPTY_N.
- Throughput: depth 2 sustains 1 transfer per cycle with simultaneous ENQ and DEQ. Depth 1 alternates, so at most 1 transfer per 2 cycles.

## Configuration
- FIFO_ERROR_CHECK_EN:
  - When defined, simulation-only checks run on every rising edge with RST_N=1 and CLR=0.
  - ENQ=1 with FULL_N=0 prints a warning: "<instance>: enqueue to full FIFO".
  - DEQ=1 with EMPTY_N=0 prints a warning: "<instance>: dequeue from empty FIFO".
  - The checks are behaviourally transparent; the request is still dropped as specified.
  - When not defined, no checks are compiled. RTL behaviour and ports are identical in both builds.

## Test plan
- Reset: hold RST_N=0 for 2 cycles with width=8, depth=2 → EMPTY_N=0, FULL_N=1, D_OUT=0x00.
- Fill depth 2: enq 0x11, then 0x22 → after the 1st edge EMPTY_N=1, D_OUT=0x11, FULL_N=1; after the 2nd edge FULL_N=0. Then enq 0x33 → dropped. With FIFO_ERROR_CHECK_EN defined, the warning is printed.
- Drain depth 2: deq, deq, deq → D_OUT 0x22, then EMPTY_N=0, then the 3rd deq is ignored with EMPTY_N still 0 and FULL_N=1.
- Simultaneous enq+deq, depth 2, count 1 (head 0xA5), enq 0x5A → count stays 1, D_OUT=0x5A, FULL_N=1.
- Depth 1: enq 0x7E → FULL_N=0, EMPTY_N=1, D_OUT=0x7E. Then ENQ=DEQ=1 with D_IN=0x01 → deq performed, enq dropped, so EMPTY_N=0 and FULL_N=1.
- CLR: with 2 entries, assert CLR together with ENQ=DEQ=1 → next cycle EMPTY_N=0, FULL_N=1. Then assert RST_N=0 during a stream → contents lost and D_OUT=0.
